// File: rtl/inst_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_fetch : program counter, in-order imem requests, 3-deep fetch buffer  |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        if_valid
);

  localparam int DEPTH = 3;

  typedef logic [1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pcq_q [DEPTH];
  logic [31:0] pcq_d [DEPTH];
  ptr_t        pcq_rd_q, pcq_rd_d;
  ptr_t        pcq_wr_q, pcq_wr_d;
  logic [1:0]  outstanding_q, outstanding_d;

  logic [31:0] fifo_pc_q   [DEPTH];
  logic [31:0] fifo_pc_d   [DEPTH];
  logic [31:0] fifo_inst_q [DEPTH];
  logic [31:0] fifo_inst_d [DEPTH];
  ptr_t        fifo_rd_q, fifo_rd_d;
  ptr_t        fifo_wr_q, fifo_wr_d;
  logic [1:0]  count_q, count_d;
  logic [1:0]  discard_q, discard_d;

  logic [2:0]  occupancy;
  logic        accept;
  logic        rsp;
  logic        push;
  logic        pop;

  always_comb begin
    // Request credit counts both in-flight reads and buffered words, so a
    // returning response always finds a free FIFO slot.
    occupancy = {1'b0, outstanding_q} + {1'b0, count_q};
    imem_req  = !rst && !flush && (occupancy < 3'd3);
    imem_addr = rst ? 32'd0 : fetch_pc_q;
    accept    = imem_req && imem_ready;
    rsp       = imem_rvalid && (outstanding_q != 2'd0);
    push      = rsp && !flush && (discard_q == 2'd0);
    pop       = (count_q != 2'd0) && !stall && !flush;

    if_valid  = !rst && (count_q != 2'd0);
    if_pc     = if_valid ? fifo_pc_q[fifo_rd_q]   : 32'd0;
    if_inst   = if_valid ? fifo_inst_q[fifo_rd_q] : 32'd0;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    pcq_d         = pcq_q;
    pcq_rd_d      = pcq_rd_q;
    pcq_wr_d      = pcq_wr_q;
    outstanding_d = outstanding_q + {1'b0, accept} - {1'b0, rsp};
    fifo_pc_d     = fifo_pc_q;
    fifo_inst_d   = fifo_inst_q;
    fifo_rd_d     = fifo_rd_q;
    fifo_wr_d     = fifo_wr_q;
    count_d       = count_q;
    discard_d     = discard_q;

    if (accept) begin
      pcq_d[pcq_wr_q] = fetch_pc_q;
      pcq_wr_d        = ptr_inc(pcq_wr_q);
      fetch_pc_d      = fetch_pc_q + 32'd4;
    end

    if (rsp) begin
      pcq_rd_d = ptr_inc(pcq_rd_q);
    end

    if (flush) begin
      // Every read still in flight is stale, including one landing right now.
      fetch_pc_d = redirect_pc;
      fifo_rd_d  = 2'd0;
      fifo_wr_d  = 2'd0;
      count_d    = 2'd0;
      discard_d  = outstanding_q - {1'b0, rsp};
    end else begin
      if (rsp && (discard_q != 2'd0)) begin
        discard_d = discard_q - 2'd1;
      end
      if (push) begin
        fifo_pc_d[fifo_wr_q]   = pcq_q[pcq_rd_q];
        fifo_inst_d[fifo_wr_q] = imem_rdata;
        fifo_wr_d              = ptr_inc(fifo_wr_q);
      end
      if (pop) begin
        fifo_rd_d = ptr_inc(fifo_rd_q);
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      pcq_rd_q      <= 2'd0;
      pcq_wr_q      <= 2'd0;
      outstanding_q <= 2'd0;
      fifo_rd_q     <= 2'd0;
      fifo_wr_q     <= 2'd0;
      count_q       <= 2'd0;
      discard_q     <= 2'd0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      pcq_rd_q      <= pcq_rd_d;
      pcq_wr_q      <= pcq_wr_d;
      outstanding_q <= outstanding_d;
      fifo_rd_q     <= fifo_rd_d;
      fifo_wr_q     <= fifo_wr_d;
      count_q       <= count_d;
      discard_q     <= discard_d;
    end
  end

  // Storage arrays need no reset: the pointers and counters gate every read.
  always_ff @(posedge clk) begin
    pcq_q       <= pcq_d;
    fifo_pc_q   <= fifo_pc_d;
    fifo_inst_q <= fifo_inst_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// tb_inst_fetch: directed phases against a latency-programmable memory model;
// a monitor pops expected {pc, inst} pairs whenever IF/ID would capture a word.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h100;
  localparam logic [31:0] XORK   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_inst    (if_inst),
    .if_pc      (if_pc),
    .if_valid   (if_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          consumed = 0;

  task automatic load_expect(input logic [31:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  mreq_t       m_e;
  int          mem_lat      = 1;
  logic [3:0]  ready_pat    = 4'b1111;
  logic [31:0] exp_acc_addr = RST_PC;
  int          cyc          = 0;

  initial begin
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      cyc++;
      imem_ready  = ready_pat[cyc % 4];
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
      if (mq.size() != 0 && mq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mq[0].addr ^ XORK;
        void'(mq.pop_front());
      end
      #1;
      if (rst) begin
        mq.delete();
        imem_rvalid = 1'b0;
      end else if (imem_req && imem_ready) begin
        check("acc_addr", imem_addr, exp_acc_addr);
        exp_acc_addr = exp_acc_addr + 32'd4;
        m_e.addr = imem_addr;
        m_e.due  = cyc + mem_lat;
        mq.push_back(m_e);
      end
    end
  end

  // ---------------- monitor ----------------
  logic        p_hold = 1'b0;
  logic        p_pend = 1'b0;
  logic [31:0] p_pc   = 32'd0;
  logic [31:0] p_inst = 32'd0;
  logic [31:0] p_addr = 32'd0;
  logic [31:0] e_pc;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        check("rst_req",   {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_inst",  if_inst, 32'd0);
        check("rst_pc",    if_pc,   32'd0);
      end else begin
        if (p_hold && !flush) begin
          check("hold_pc",   if_pc,   p_pc);
          check("hold_inst", if_inst, p_inst);
        end
        if (p_pend && !flush) begin
          check("pend_req",  {31'd0, imem_req}, 32'd1);
          check("pend_addr", imem_addr, p_addr);
        end
        if (!if_valid) begin
          check("bubble_inst", if_inst, 32'd0);
          check("bubble_pc",   if_pc,   32'd0);
        end
        if (if_valid && !stall && !flush) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL stream_extra: got pc %h, want no instruction", if_pc);
          end else begin
            e_pc = exp_q.pop_front();
            check("stream_pc",   if_pc,   e_pc);
            check("stream_inst", if_inst, e_pc ^ XORK);
            consumed++;
          end
        end
        check("occupancy_le3",
              {31'd0, (int'(dut.outstanding_q) + int'(dut.count_q)) <= 3}, 32'd1);
      end
      p_hold = !rst && !flush && if_valid && stall;
      p_pend = !rst && !flush && imem_req && !imem_ready;
      p_pc   = if_pc;
      p_inst = if_inst;
      p_addr = imem_addr;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  int   c0;
  logic found;

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 32'd0;
    tick(); tick();

    // Reset release and first-fetch latency
    tick();
    rst = 1'b0;
    load_expect(RST_PC, 200);
    exp_acc_addr = RST_PC;
    #3;
    check("r1_req",   {31'd0, imem_req}, 32'd1);
    check("r1_addr",  imem_addr, RST_PC);
    check("r1_valid", {31'd0, if_valid}, 32'd0);
    tick(); #3;
    check("r2_valid", {31'd0, if_valid}, 32'd0);
    tick(); #3;
    check("r3_valid", {31'd0, if_valid}, 32'd1);
    check("r3_pc",    if_pc, RST_PC);
    repeat (8) begin
      tick(); #3;
      check("no_bubble", {31'd0, if_valid}, 32'd1);
    end

    // Five-cycle stall: the buffer fills and requests stop
    tick();
    stall = 1'b1;
    repeat (4) tick();
    #3;
    check("stall_occ",   32'(int'(dut.outstanding_q) + int'(dut.count_q)), 32'd3);
    check("stall_count", {30'd0, dut.count_q}, 32'd3);
    check("stall_req",   {31'd0, imem_req}, 32'd0);
    tick();
    stall = 1'b0;
    repeat (8) tick();

    // imem_ready 1-0-0-1 with 3-cycle read latency
    c0 = consumed;
    mem_lat   = 3;
    ready_pat = 4'b1001;
    repeat (30) tick();
    check("ready_progress", {31'd0, (consumed - c0) >= 5}, 32'd1);

    // Flush with two requests in flight and a word buffered
    mem_lat   = 2;
    ready_pat = 4'b1111;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (dut.outstanding_q == 2'd2 && dut.count_q != 2'd0) found = 1'b1;
    end
    check("flush_setup", {31'd0, found}, 32'd1);
    flush = 1'b1;
    redirect_pc = 32'h2000;
    load_expect(32'h2000, 64);
    exp_acc_addr = 32'h2000;
    #3;
    check("f0_req", {31'd0, imem_req}, 32'd0);
    tick();
    flush = 1'b0;
    #3;
    check("f1_valid", {31'd0, if_valid}, 32'd0);
    check("f1_req",   {31'd0, imem_req}, 32'd1);
    check("f1_addr",  imem_addr, 32'h2000);
    tick(); #3;
    check("f2_valid", {31'd0, if_valid}, 32'd0);
    c0 = consumed;
    repeat (10) tick();
    check("flush_progress", {31'd0, (consumed - c0) >= 3}, 32'd1);

    // Flush and stall together with a response landing the same cycle
    mem_lat = 1;
    repeat (6) tick();
    tick();
    stall = 1'b1;
    flush = 1'b1;
    redirect_pc = 32'h3000;
    load_expect(32'h3000, 64);
    exp_acc_addr = 32'h3000;
    #3;
    check("fs_rvalid", {31'd0, imem_rvalid}, 32'd1);
    check("fs_req",    {31'd0, imem_req}, 32'd0);
    tick();
    stall = 1'b0;
    flush = 1'b0;
    #3;
    check("fs1_req",   {31'd0, imem_req}, 32'd1);
    check("fs1_addr",  imem_addr, 32'h3000);
    check("fs1_valid", {31'd0, if_valid}, 32'd0);
    c0 = consumed;
    repeat (8) tick();
    check("fs_progress", {31'd0, (consumed - c0) >= 4}, 32'd1);

    // One-cycle reset mid-stream
    tick();
    rst = 1'b1;
    load_expect(RST_PC, 64);
    exp_acc_addr = RST_PC;
    #3;
    check("mr_valid", {31'd0, if_valid}, 32'd0);
    tick();
    rst = 1'b0;
    #3;
    check("mr1_req",   {31'd0, imem_req}, 32'd1);
    check("mr1_addr",  imem_addr, RST_PC);
    check("mr1_valid", {31'd0, if_valid}, 32'd0);
    tick(); tick(); #3;
    check("mr3_valid", {31'd0, if_valid}, 32'd1);
    check("mr3_pc",    if_pc, RST_PC);
    c0 = consumed;
    repeat (6) tick();
    check("mr_progress", {31'd0, (consumed - c0) >= 5}, 32'd1);

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
